// File: rtl/fb_arbiter.sv
// Framebuffer arbiter: shares one synchronous RAM port between display reads and a pixel writer.
// Define FB_STALL_CNT_EN to build the saturating write-stall counter; otherwise wr_stall_cnt_o is 0.
module fb_arbiter (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [9:0]  hcount_i,
  input  logic [9:0]  vcount_i,
  input  logic        vid_i,
  input  logic        wr_req_i,
  input  logic [18:0] wr_addr_i,
  input  logic [7:0]  wr_data_i,
  output logic        wr_ack_o,
  output logic [18:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [7:0]  mem_wdata_o,
  input  logic [7:0]  mem_rdata_i,
  output logic [7:0]  pix_out_o,
  output logic        pix_valid_o,
  output logic        frame_start_o,
  output logic [15:0] wr_stall_cnt_o
);

  // state   | meaning
  // S_IDLE  | no RAM access; address/data registers hold
  // S_READ  | display fetch at {vcount,hcount}
  // S_WRITE | writer commit; wr_ack high this cycle
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [18:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic        rd_d1_q;
  logic        pix_valid_q;
  logic [7:0]  pix_out_q;
  logic        zero_q;
  logic        frame_start_q;
  logic        zero_now;
  logic        unused_vcount_msb;

  assign unused_vcount_msb = vcount_i[9];
  assign zero_now          = (hcount_i == 10'd0) && (vcount_i == 10'd0);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Display always wins; a write cannot start in its own ack cycle.
  always_comb begin
    state_d = S_IDLE;
    if (vid_i)                       state_d = S_READ;
    else if (wr_req_i && !wr_ack_o)  state_d = S_WRITE;
  end

  always_comb begin
    wr_ack_o    = (state_q == S_WRITE);
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    case (state_d)
      S_READ:  mem_addr_d = {vcount_i[8:0], hcount_i};
      S_WRITE: begin
        mem_addr_d  = wr_addr_i;
        mem_wdata_d = wr_data_i;
        mem_we_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
    end
  end

  // Read return: RAM data lands one cycle after the address, then gets registered.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_d1_q     <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_out_q   <= '0;
    end else begin
      rd_d1_q     <= (state_q == S_READ);
      pix_valid_q <= rd_d1_q;
      pix_out_q   <= rd_d1_q ? mem_rdata_i : 8'h00;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      zero_q        <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      zero_q        <= zero_now;
      frame_start_q <= zero_now && !zero_q;
    end
  end

`ifdef FB_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (frame_start_q)
      stall_cnt_d = 16'h0000;
    else if (wr_req_i && !wr_ack_o && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign wr_stall_cnt_o = stall_cnt_q;
`else
  assign wr_stall_cnt_o = 16'h0000;
`endif

  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign mem_we_o      = mem_we_q;
  assign pix_valid_o   = pix_valid_q;
  assign pix_out_o     = pix_out_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: directed steps, write and pixel scoreboards, RAM model.
module tb_fb_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [9:0]  hcount_i;
  logic [9:0]  vcount_i;
  logic        vid_i;
  logic        wr_req_i;
  logic [18:0] wr_addr_i;
  logic [7:0]  wr_data_i;
  logic        wr_ack_o;
  logic [18:0] mem_addr_o;
  logic        mem_we_o;
  logic [7:0]  mem_wdata_o;
  logic [7:0]  mem_rdata_i = 8'h00;
  logic [7:0]  pix_out_o;
  logic        pix_valid_o;
  logic        frame_start_o;
  logic [15:0] wr_stall_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0]  exp_pix[$];
  logic [26:0] wr_q[$];

`ifdef FB_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  fb_arbiter dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .hcount_i       (hcount_i),
    .vcount_i       (vcount_i),
    .vid_i          (vid_i),
    .wr_req_i       (wr_req_i),
    .wr_addr_i      (wr_addr_i),
    .wr_data_i      (wr_data_i),
    .wr_ack_o       (wr_ack_o),
    .mem_addr_o     (mem_addr_o),
    .mem_we_o       (mem_we_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i),
    .pix_out_o      (pix_out_o),
    .pix_valid_o    (pix_valid_o),
    .frame_start_o  (frame_start_o),
    .wr_stall_cnt_o (wr_stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] ram_f(input logic [18:0] a);
    return a[7:0] + 8'h37;
  endfunction

  function automatic logic [15:0] stall_exp(input int v);
    return STALL_EN ? 16'(v) : 16'h0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_ack"},      32'(wr_ack_o),       32'd0);
    check({tag, "_mem_addr"},    32'(mem_addr_o),     32'd0);
    check({tag, "_mem_we"},      32'(mem_we_o),       32'd0);
    check({tag, "_mem_wdata"},   32'(mem_wdata_o),    32'd0);
    check({tag, "_pix_out"},     32'(pix_out_o),      32'd0);
    check({tag, "_pix_valid"},   32'(pix_valid_o),    32'd0);
    check({tag, "_frame_start"}, 32'(frame_start_o),  32'd0);
    check({tag, "_stall_cnt"},   32'(wr_stall_cnt_o), 32'd0);
  endtask

  // Synchronous RAM: contents are a fixed function of the address.
  always @(posedge clk_i) mem_rdata_i <= ram_f(mem_addr_o);

  // Expected pixel for what the display requested this edge.
  always @(posedge clk_i) begin
    if (reset_i) exp_pix.delete();
    else exp_pix.push_back(vid_i ? {1'b1, ram_f({vcount_i[8:0], hcount_i})} : 9'h000);
  end

  always @(negedge clk_i) begin : monitor
    logic [8:0]  e;
    logic [26:0] w;
    if (!reset_i) begin
      e = 9'h000;
      if (exp_pix.size() >= 3) e = exp_pix.pop_front();
      check("pix_valid", 32'(pix_valid_o), 32'(e[8]));
      check("pix_out",   32'(pix_out_o),   32'(e[7:0]));
      check("ack_eq_we", 32'(wr_ack_o),    32'(mem_we_o));
      if (mem_we_o) begin
        if (wr_q.size() > 0) begin
          w = wr_q.pop_front();
          check("wr_addr", 32'(mem_addr_o),  32'(w[26:8]));
          check("wr_data", 32'(mem_wdata_o), 32'(w[7:0]));
        end else begin
          check("unexpected_write", 32'(mem_we_o), 32'd0);
        end
      end
    end
  end

  // Called just after a falling edge; returns on the falling edge where the ack is seen.
  task automatic do_write(input logic [18:0] a, input logic [7:0] d, input int exp_lat);
    int n;
    wr_addr_i = a;
    wr_data_i = d;
    wr_req_i  = 1'b1;
    wr_q.push_back({a, d});
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!wr_ack_o && n < 20);
    check("wr_ack_seen", 32'(wr_ack_o), 32'd1);
    check("wr_latency",  32'(n),        32'(exp_lat));
    wr_req_i = 1'b0;
  endtask

  initial begin
    reset_i   = 1'b1;
    hcount_i  = 10'd1;
    vcount_i  = 10'd1;
    vid_i     = 1'b0;
    wr_req_i  = 1'b0;
    wr_addr_i = '0;
    wr_data_i = '0;

    // Reset state
    @(negedge clk_i);
    check_all_zero("reset");
    @(negedge clk_i);
    reset_i = 1'b0;
    repeat (3) @(negedge clk_i);

    // Write during blanking
    do_write(19'h00123, 8'hA5, 1);
    check("blank_stall_cnt", 32'(wr_stall_cnt_o), 32'(stall_exp(1)));
    @(negedge clk_i);
    check("blank_ack_one_cycle", 32'(wr_ack_o), 32'd0);

    // Back-to-back: second write cannot start in the first one's ack cycle
    do_write(19'h7FFFF, 8'h5A, 1);
    do_write(19'h40001, 8'hC3, 2);
    @(negedge clk_i);

    // Read latency
    vid_i = 1'b1; hcount_i = 10'd5; vcount_i = 10'd2;
    @(negedge clk_i);
    check("rd_mem_addr", 32'(mem_addr_o), 32'h00805);
    check("rd_mem_we",   32'(mem_we_o),   32'd0);
    vid_i = 1'b0; hcount_i = 10'd1; vcount_i = 10'd1;
    @(negedge clk_i);
    check("rd_not_early", 32'(pix_valid_o), 32'd0);
    @(negedge clk_i);
    check("rd_pix_out",   32'(pix_out_o),   32'h3C);
    check("rd_pix_valid", 32'(pix_valid_o), 32'd1);
    @(negedge clk_i);
    check("rd_pix_drop",  32'(pix_valid_o), 32'd0);

    // Burst of display reads at varying addresses
    vid_i = 1'b1; vcount_i = 10'd300;
    for (int i = 0; i < 6; i++) begin
      hcount_i = 10'(600 + 37 * i);
      @(negedge clk_i);
    end
    vid_i = 1'b0; hcount_i = 10'd1; vcount_i = 10'd1;
    repeat (3) @(negedge clk_i);

    // Frame boundary: one pulse per occurrence, counter cleared after it
    hcount_i = 10'd0; vcount_i = 10'd0;
    @(negedge clk_i);
    check("frame_pulse", 32'(frame_start_o), 32'd1);
    @(negedge clk_i);
    check("frame_one_cycle",  32'(frame_start_o),  32'd0);
    check("frame_stall_clr",  32'(wr_stall_cnt_o), 32'd0);
    @(negedge clk_i);
    check("frame_no_repeat", 32'(frame_start_o), 32'd0);
    hcount_i = 10'd1;
    @(negedge clk_i);
    check("frame_cleared", 32'(frame_start_o), 32'd0);
    hcount_i = 10'd0;
    @(negedge clk_i);
    check("frame_recur", 32'(frame_start_o), 32'd1);
    hcount_i = 10'd7; vcount_i = 10'd1;
    @(negedge clk_i);
    check("frame_recur_end", 32'(frame_start_o), 32'd0);

    // Preemption: write waits out 5 read cycles
    wr_addr_i = 19'h2ABCD; wr_data_i = 8'h81; wr_req_i = 1'b1; vid_i = 1'b1;
    wr_q.push_back({19'h2ABCD, 8'h81});
    for (int i = 0; i < 5; i++) begin
      hcount_i = 10'(200 + i);
      @(negedge clk_i);
      check("preempt_no_ack", 32'(wr_ack_o), 32'd0);
    end
    vid_i = 1'b0;
    @(negedge clk_i);
    check("preempt_ack",       32'(wr_ack_o),       32'd1);
    check("preempt_stall_cnt", 32'(wr_stall_cnt_o), 32'(stall_exp(6)));
    wr_req_i = 1'b0;
    @(negedge clk_i);
    check("preempt_ack_once", 32'(wr_ack_o), 32'd0);

    // Reset in the middle of a write
    wr_addr_i = 19'h01111; wr_data_i = 8'h22; wr_req_i = 1'b1;
    wr_q.push_back({19'h01111, 8'h22});
    @(negedge clk_i);
    check("midwr_we_before", 32'(mem_we_o), 32'd1);
    #1 reset_i = 1'b1;
    #1 check_all_zero("midwr");
    wr_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      check("midwr_no_ack", 32'(wr_ack_o), 32'd0);
    end

    // Request held across reset is taken on the very first edge afterwards
    wr_addr_i = 19'h0BEEF; wr_data_i = 8'h99; wr_req_i = 1'b1;
    #1 reset_i = 1'b1;
    @(negedge clk_i);
    check("rstheld_no_ack", 32'(wr_ack_o), 32'd0);
    reset_i = 1'b0;
    wr_q.push_back({19'h0BEEF, 8'h99});
    @(negedge clk_i);
    check("rstheld_first_edge", 32'(wr_ack_o), 32'd1);
    wr_req_i = 1'b0;
    @(negedge clk_i);

    // Long preemption: counter saturates instead of wrapping
    hcount_i = 10'd3; vcount_i = 10'd3;
    wr_addr_i = 19'h12345; wr_data_i = 8'h6E; wr_req_i = 1'b1; vid_i = 1'b1;
    wr_q.push_back({19'h12345, 8'h6E});
    repeat (70000) @(negedge clk_i);
    check("sat_no_ack",    32'(wr_ack_o),       32'd0);
    check("sat_stall_cnt", 32'(wr_stall_cnt_o), 32'(STALL_EN ? 16'hFFFF : 16'h0000));
    vid_i = 1'b0;
    @(negedge clk_i);
    check("sat_ack",       32'(wr_ack_o),       32'd1);
    check("sat_hold",      32'(wr_stall_cnt_o), 32'(STALL_EN ? 16'hFFFF : 16'h0000));
    wr_req_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("wr_queue_drained", 32'(wr_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 clk  input  1  system pixel clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 hcount  input  10  horizontal pixel count from the display timing generator.
REQ-004 vcount  input  10  vertical line count from the display timing generator.
REQ-005 vid  input  1  active-video flag from the display timing generator.
REQ-006 wr_req  input  1  writer requests one framebuffer write; held with wr_addr/wr_data stable until wr_ack.
REQ-007 wr_addr  input  19  writer target address.
REQ-008 wr_data  input  8  writer pixel data.
REQ-009 wr_ack  output  1  one-cycle pulse; write committed this cycle.
REQ-010 mem_addr  output  19  registered RAM address.
REQ-011 mem_we  output  1  registered RAM write enable.
REQ-012 mem_wdata  output  8  registered RAM write data.
REQ-013 mem_rdata  input  8  synchronous RAM read data, valid one cycle after mem_addr.
REQ-014 pix_out  output  8  pixel to the video DAC; 0 when pix_valid=0.
REQ-015 pix_valid  output  1  pix_out carries framebuffer data.
REQ-016 frame_start  output  1  one-cycle pulse at start of each frame.
REQ-017 wr_stall_cnt  output  16  write stall cycle counter (see Configuration).

Function
REQ-018 The FSM SHALL have states S_IDLE, S_READ, S_WRITE, with next state decided from inputs sampled at each rising edge.
REQ-019 Priority: vid=1 -> S_READ; else wr_req=1 and wr_ack=0 -> S_WRITE; else S_IDLE.
REQ-020 S_READ: mem_addr={vcount[8:0],hcount[9:0]} sampled the previous edge, mem_we=0.
REQ-021 S_WRITE: mem_addr=wr_addr, mem_wdata=wr_data, mem_we=1, wr_ack=1, all in the same cycle.
REQ-022 S_IDLE: mem_we=0, wr_ack=0, mem_addr and mem_wdata hold last values.
REQ-023 Back-to-back writes: a new write SHALL not start in the cycle wr_ack is high; max write rate is one write per two cycles.
REQ-024 Display reads SHALL preempt writes: vid=1 sampled at edge N forces S_READ at N+1 even if wr_req is pending; the write waits, no data loss.
REQ-025 Read pipeline: vid sampled at edge N -> pix_valid=1 and pix_out=mem_rdata at cycle N+3 (address reg, RAM, output reg); fixed 3-cycle latency.
REQ-026 When the delayed vid is 0, pix_out=0 and pix_valid=0.
REQ-027 frame_start SHALL pulse for one cycle the cycle after hcount=0 and vcount=0 are first sampled together; no repeat until that condition clears and recurs.
REQ-028 wr_ack SHALL never assert while mem_we=0, nor for more than one cycle per request.

Reset
REQ-029 On reset, all outputs SHALL be 0 and state S_IDLE, asynchronously, regardless of pipeline contents.
REQ-030 A write pending or in flight at reset SHALL be discarded without wr_ack; the writer must re-request after reset.
REQ-031 After reset deasserts, the first edge SHALL follow the normal priority rules; no extra idle cycles.

Configuration
REQ-032 With FB_STALL_CNT_EN defined, wr_stall_cnt SHALL count cycles with wr_req=1 and wr_ack=0, saturate at 16'hFFFF, and clear to 0 on frame_start (clear wins over increment).
REQ-033 Without FB_STALL_CNT_EN, wr_stall_cnt SHALL be tied to 0 and the counter SHALL not be synthesized.

Verification
REQ-034 Reset mid-write: assert reset while mem_we=1 -> all outputs 0 immediately; no wr_ack after release until wr_req is resampled.
REQ-035 Blanking write: vid=0, wr_req=1, wr_addr=19'h00123, wr_data=8'hA5 -> next cycle mem_we=1, mem_addr=19'h00123, mem_wdata=8'hA5, wr_ack=1 for exactly one cycle.
REQ-036 Preemption: wr_req held, vid rises -> no wr_ack while vid=1; write completes the cycle after vid is first sampled 0; stall counter (enabled) equals stalled cycles.
REQ-037 Read latency: vid=1, hcount=5, vcount=2 at edge N -> mem_addr=19'h00805 at N+1; RAM model returns 8'h3C -> pix_out=8'h3C, pix_valid=1 at N+3.
REQ-038 Frame boundary: hcount=0 and vcount=0 -> frame_start high exactly one cycle; wr_stall_cnt=0 the following cycle.
REQ-039 Saturation (FB_STALL_CNT_EN): wr_req held, vid=1 for 70000 cycles, no frame_start -> wr_stall_cnt=16'hFFFF, no wrap.
